// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute and writeback.
// Latches the execute result and runs the load/store on the data SRAM
// through a req/addr_ok/data_ok handshake. It aligns and extends load data
// and hands the result to writeback through a valid/allowin handshake.
// Optional build macro: MEM_ALIGN_CHECK_EN adds mem_exc. Misaligned half/word
// accesses then skip the SRAM and complete as an exception.
module memory_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               exe_valid,
  output logic               mem_allowin,
  input  logic               exe_reg_en,
  input  logic [RADDR_W-1:0] exe_reg_waddr,
  input  logic               exe_mem_read,
  input  logic               exe_mem_write,
  input  logic [1:0]         exe_mem_size,
  input  logic               exe_mem_unsigned,
  input  logic [DATA_W-1:0]  exe_alu_result,
  input  logic [DATA_W-1:0]  exe_store_data,
  output logic               data_req,
  output logic               data_wr,
  output logic [3:0]         data_wstrb,
  output logic [DATA_W-1:0]  data_addr,
  output logic [DATA_W-1:0]  data_wdata,
  input  logic               data_addr_ok,
  input  logic               data_data_ok,
  input  logic [DATA_W-1:0]  data_rdata,
  output logic               mem_valid,
  input  logic               wb_allowin,
  output logic               mem_reg_en,
  output logic [RADDR_W-1:0] mem_reg_waddr,
  output logic               mem_mem_read,
  output logic [DATA_W-1:0]  alu_result_reg,
  output logic [DATA_W-1:0]  mem_rdata
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic               mem_exc
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Instruction fields captured at acceptance
  logic               reg_en_q;
  logic [RADDR_W-1:0] waddr_q;
  logic               rd_q;
  logic               wr_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [DATA_W-1:0]  alu_q;
  logic [DATA_W-1:0]  sd_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               exc_in;

  logic               accept;
  logic               is_mem_in;
  state_e             go_state;
  logic [DATA_W-1:0]  load_aligned;
  logic [3:0]         strobe;

  assign accept    = exe_valid && mem_allowin;
  assign is_mem_in = exe_mem_read || exe_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  logic exc_q;
  // Half needs addr[0]==0, word (size 10/11) needs addr[1:0]==0
  assign exc_in = is_mem_in &&
                  (((exe_mem_size == 2'b01) && exe_alu_result[0]) ||
                   (exe_mem_size[1] && (exe_alu_result[1:0] != 2'b00)));
  assign mem_exc = exc_q && mem_valid;
`else
  assign exc_in = 1'b0;
`endif

  // Where a freshly accepted instruction goes: SRAM access or straight to DONE
  assign go_state = (is_mem_in && !exc_in) ? S_REQ : S_DONE;

  // Next-state logic for the access sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = go_state;
      S_REQ:  if (data_addr_ok) state_d = S_WAIT;
      S_WAIT: if (data_data_ok) state_d = S_DONE;
      S_DONE: if (wb_allowin) state_d = accept ? go_state : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Latch instruction fields on acceptance; capture load data on data_ok
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_en_q <= 1'b0;
      waddr_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      alu_q    <= '0;
      sd_q     <= '0;
      rdata_q  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      exc_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        reg_en_q <= exe_reg_en;
        waddr_q  <= exe_reg_waddr;
        rd_q     <= exe_mem_read;
        wr_q     <= exe_mem_write;
        size_q   <= exe_mem_size;
        uns_q    <= exe_mem_unsigned;
        alu_q    <= exe_alu_result;
        sd_q     <= exe_store_data;
`ifdef MEM_ALIGN_CHECK_EN
        exc_q    <= exc_in;
`endif
      end
      if ((state_q == S_WAIT) && data_data_ok && rd_q) rdata_q <= load_aligned;
    end
  end

  // Select the addressed byte/half lane of the read word and extend it
  always_comb begin
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    unique case (alu_q[1:0])
      2'd0:    byte_lane = data_rdata[7:0];
      2'd1:    byte_lane = data_rdata[15:8];
      2'd2:    byte_lane = data_rdata[23:16];
      default: byte_lane = data_rdata[31:24];
    endcase
    half_lane = alu_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    unique case (size_q)
      2'b00:   load_aligned = {{(DATA_W-8){byte_lane[7] & ~uns_q}}, byte_lane};
      2'b01:   load_aligned = {{(DATA_W-16){half_lane[15] & ~uns_q}}, half_lane};
      default: load_aligned = data_rdata;
    endcase
  end

  // Byte-enable pattern for stores; sub-size address bits are ignored
  always_comb begin
    unique case (size_q)
      2'b00:   strobe = 4'b0001 << alu_q[1:0];
      2'b01:   strobe = 4'b0011 << {alu_q[1], 1'b0};
      default: strobe = 4'b1111;
    endcase
  end

  // Lane replication of store data: every lane carries the data it would need
  // wherever the strobes land
  for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
    assign data_wdata[gi*8 +: 8] = (size_q == 2'b00) ? sd_q[7:0] :
                                   (size_q == 2'b01) ? sd_q[(gi%2)*8 +: 8] :
                                                       sd_q[gi*8 +: 8];
  end

  assign data_req    = (state_q == S_REQ);
  assign data_wr     = wr_q;
  assign data_wstrb  = wr_q ? strobe : 4'b0000;
  assign data_addr   = {alu_q[DATA_W-1:2], 2'b00};

  assign mem_allowin    = (state_q == S_IDLE) || ((state_q == S_DONE) && wb_allowin);
  assign mem_valid      = (state_q == S_DONE);
`ifdef MEM_ALIGN_CHECK_EN
  assign mem_reg_en     = mem_valid && reg_en_q && !exc_q;
`else
  assign mem_reg_en     = mem_valid && reg_en_q;
`endif
  assign mem_reg_waddr  = waddr_q;
  assign mem_mem_read   = rd_q;
  assign alu_result_reg = alu_q;
  assign mem_rdata      = rdata_q;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed test-plan steps followed by random
// instructions, checked against a word-array SRAM model and arithmetic
// alignment/strobe rules.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_valid;
  logic        mem_allowin;
  logic        exe_reg_en;
  logic [4:0]  exe_reg_waddr;
  logic        exe_mem_read;
  logic        exe_mem_write;
  logic [1:0]  exe_mem_size;
  logic        exe_mem_unsigned;
  logic [31:0] exe_alu_result;
  logic [31:0] exe_store_data;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_valid;
  logic        wb_allowin;
  logic        mem_reg_en;
  logic [4:0]  mem_reg_waddr;
  logic        mem_mem_read;
  logic [31:0] alu_result_reg;
  logic [31:0] mem_rdata;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_exc;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem_model [256];

  memory_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .exe_valid(exe_valid), .mem_allowin(mem_allowin),
    .exe_reg_en(exe_reg_en), .exe_reg_waddr(exe_reg_waddr),
    .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write),
    .exe_mem_size(exe_mem_size), .exe_mem_unsigned(exe_mem_unsigned),
    .exe_alu_result(exe_alu_result), .exe_store_data(exe_store_data),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_valid(mem_valid), .wb_allowin(wb_allowin),
    .mem_reg_en(mem_reg_en), .mem_reg_waddr(mem_reg_waddr),
    .mem_mem_read(mem_mem_read), .alu_result_reg(alu_result_reg), .mem_rdata(mem_rdata)
`ifdef MEM_ALIGN_CHECK_EN
    , .mem_exc(mem_exc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Put random junk on the execute-side fields while exe_valid is low
  task automatic scramble_exe();
    exe_reg_en       = 1'($urandom);
    exe_reg_waddr    = 5'($urandom);
    exe_mem_read     = 1'($urandom);
    exe_mem_write    = 1'($urandom);
    exe_mem_size     = 2'($urandom);
    exe_mem_unsigned = 1'($urandom);
    exe_alu_result   = $urandom;
    exe_store_data   = $urandom;
  endtask

  // One instruction from issue to retirement. a_dly/d_dly are SRAM wait
  // cycles, wb_dly is writeback back-pressure, pend offers a non-memory
  // instruction during the stall that must be taken as wb_allowin rises.
  task automatic do_instr(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] sd, input bit ren,
                          input logic [4:0] wa, input int a_dly, input int d_dly,
                          input int wb_dly, input bit pend);
    logic [31:0] w, w2, mask, v, exp_strb, exp_wd, exp_ld, p_alu;
    logic [7:0]  idx;
    logic [4:0]  p_wa;
    bit          p_ren, mis, memop;
    int          sh;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (rd || wr) && ((sz == 2'd1 && addr[0]) || (sz >= 2'd2 && addr[1:0] != 2'd0));
`endif
    memop = (rd || wr) && !mis;
    idx   = addr[9:2];
    w     = mem_model[idx];
    // reference alignment rules
    if (sz == 2'd0)      begin mask = 32'hFF;   sh = 8 * int'(addr[1:0]); end
    else if (sz == 2'd1) begin mask = 32'hFFFF; sh = 16 * int'(addr[1]); end
    else                 begin mask = 32'hFFFF_FFFF; sh = 0; end
    v = (w >> sh) & mask;
    if (!uns && sz < 2'd2 && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
    exp_ld = v;
    if (sz == 2'd0)      begin exp_strb = 32'd1 << addr[1:0];        exp_wd = (sd & 32'hFF) * 32'h0101_0101; end
    else if (sz == 2'd1) begin exp_strb = 32'd3 << (2 * addr[1]);    exp_wd = (sd & 32'hFFFF) * 32'h0001_0001; end
    else                 begin exp_strb = 32'd15;                    exp_wd = sd; end
    p_alu = $urandom; p_wa = 5'($urandom); p_ren = 1'($urandom);

    @(negedge clk);
    exe_valid = 1'b1; exe_mem_read = rd; exe_mem_write = wr; exe_mem_size = sz;
    exe_mem_unsigned = uns; exe_alu_result = addr; exe_store_data = sd;
    exe_reg_en = ren; exe_reg_waddr = wa; wb_allowin = 1'b1;
    #1;
    chk("idle_valid", mem_valid, 0);
    chk("idle_allowin", mem_allowin, 1);
    @(negedge clk);
    exe_valid = 1'b0;
    scramble_exe();
    if (memop) begin
      for (int k = 0; k <= a_dly; k++) begin
        #1;
        chk("req", data_req, 1);
        chk("addr", data_addr, addr & 32'hFFFF_FFFC);
        chk("wr", data_wr, wr);
        chk("wstrb", data_wstrb, wr ? exp_strb : 32'd0);
        if (wr) chk("wdata", data_wdata, exp_wd);
        chk("busy_allowin", mem_allowin, 0);
        data_addr_ok = (k == a_dly);
        @(negedge clk);
      end
      data_addr_ok = 1'b0;
      for (int k = 0; k <= d_dly; k++) begin
        #1;
        chk("wait_req", data_req, 0);
        chk("wait_valid", mem_valid, 0);
        data_rdata = $urandom;
        if (k == d_dly) begin
          data_data_ok = 1'b1;
          if (rd) data_rdata = w;
        end
        @(negedge clk);
      end
      data_data_ok = 1'b0;
      data_rdata = $urandom;
      if (wr) begin
        w2 = w;
        for (int b = 0; b < 4; b++) if (exp_strb[b]) w2[8*b +: 8] = exp_wd[8*b +: 8];
        mem_model[idx] = w2;
      end
    end
    for (int k = 0; k <= wb_dly; k++) begin
      wb_allowin = (k == wb_dly);
      if (pend) begin
        exe_valid = 1'b1; exe_mem_read = 1'b0; exe_mem_write = 1'b0;
        exe_alu_result = p_alu; exe_reg_waddr = p_wa; exe_reg_en = p_ren;
      end
      #1;
      chk("done_valid", mem_valid, 1);
      chk("done_allowin", mem_allowin, (k == wb_dly) ? 32'd1 : 32'd0);
      chk("done_req", data_req, 0);
      chk("reg_en", mem_reg_en, ren && !mis);
      chk("waddr", mem_reg_waddr, wa);
      chk("mem_read", mem_mem_read, rd);
      chk("alu_reg", alu_result_reg, addr);
      if (rd && !mis) chk("rdata", mem_rdata, exp_ld);
`ifdef MEM_ALIGN_CHECK_EN
      chk("exc", mem_exc, mis);
`endif
      if (k < wb_dly) @(negedge clk);
    end
    if (pend) begin
      @(negedge clk);
      exe_valid = 1'b0;
      #1;
      chk("pend_valid", mem_valid, 1);
      chk("pend_alu", alu_result_reg, p_alu);
      chk("pend_waddr", mem_reg_waddr, p_wa);
      chk("pend_reg_en", mem_reg_en, p_ren);
    end
    $display("instr rd=%0d wr=%0d sz=%0d uns=%0d addr=%h sd=%h a_dly=%0d d_dly=%0d wb_dly=%0d pend=%0d",
             rd, wr, sz, uns, addr, sd, a_dly, d_dly, wb_dly, pend);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
    reset = 1'b1; exe_valid = 1'b0; wb_allowin = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    exe_reg_en = 0; exe_reg_waddr = 0; exe_mem_read = 0; exe_mem_write = 0;
    exe_mem_size = 0; exe_mem_unsigned = 0; exe_alu_result = 0; exe_store_data = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", mem_valid, 0);
    chk("rst_reg_en", mem_reg_en, 0);
    chk("rst_req", data_req, 0);
    chk("rst_allowin", mem_allowin, 1);
    chk("rst_alu", alu_result_reg, 0);
    chk("rst_rdata", mem_rdata, 0);
    $display("reset checked");

    // Back-to-back non-memory ops: one retirement per cycle
    @(negedge clk);
    exe_valid = 1'b1; exe_mem_read = 0; exe_mem_write = 0; exe_reg_en = 1'b1;
    exe_alu_result = 32'h1234; exe_reg_waddr = 5'd0; wb_allowin = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      #1;
      chk("b2b_valid", mem_valid, 1);
      chk("b2b_reg_en", mem_reg_en, 1);
      chk("b2b_alu", alu_result_reg, 32'h1234);
      chk("b2b_waddr", mem_reg_waddr, 5'(i - 1));
      chk("b2b_allowin", mem_allowin, 1);
      chk("b2b_req", data_req, 0);
      if (i < 6) exe_reg_waddr = 5'(i);
      else exe_valid = 1'b0;
      $display("b2b retire %0d", i - 1);
    end
    @(negedge clk);
    #1;
    chk("b2b_drain", mem_valid, 0);

    // LB / LBU at 0x103 with read word 0x80FF_FFFF
    mem_model[8'h40] = 32'h80FF_FFFF;
    do_instr(1, 0, 2'd0, 0, 32'h103, 32'h0, 1, 5'd5, 2, 0, 0, 0);
    chk("lb_const", mem_rdata, 32'hFFFF_FF80);
    do_instr(1, 0, 2'd0, 1, 32'h103, 32'h0, 1, 5'd6, 2, 0, 0, 0);
    chk("lbu_const", mem_rdata, 32'h0000_0080);

    // SH at 0x202
    do_instr(0, 1, 2'd1, 0, 32'h202, 32'hABCD_1234, 0, 5'd0, 0, 0, 0, 0);
    chk("sh_mem", mem_model[8'h80][31:16], 32'h1234);

    // Load stalled in DONE for 3 cycles with a follower waiting
    do_instr(1, 0, 2'd2, 0, 32'h300, 32'h0, 1, 5'd9, 1, 1, 3, 1);

    // Reset while waiting for data_ok that never arrives
    @(negedge clk);
    exe_valid = 1'b1; exe_mem_read = 1'b1; exe_mem_write = 1'b0; exe_mem_size = 2'd2;
    exe_alu_result = 32'h40; exe_reg_en = 1'b1; wb_allowin = 1'b1;
    @(negedge clk);
    exe_valid = 1'b0;
    #1;
    chk("rw_req", data_req, 1);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    #1;
    chk("rw_wait_req", data_req, 0);
    chk("rw_wait_valid", mem_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw_valid", mem_valid, 0);
    chk("rw_req0", data_req, 0);
    chk("rw_allowin", mem_allowin, 1);
    chk("rw_reg_en", mem_reg_en, 0);
    $display("reset during WAIT checked");

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned word load: no SRAM request, exception in DONE
    do_instr(1, 0, 2'd2, 0, 32'h1002, 32'h0, 1, 5'd3, 0, 0, 0, 0);
`endif

    // Random instruction mix
    for (int n = 0; n < 40; n++) begin
      int op;
      op = int'($urandom_range(0, 2));
      do_instr(op == 1, op == 2, 2'($urandom), 1'($urandom), $urandom, $urandom,
               1'($urandom), 5'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline stage between execute and writeback. Registers the execute-stage result, performs the load/store on the data SRAM through a request/address-ok/data-ok handshake, and aligns and extends load data. Presents `mem_reg_en`, `mem_reg_waddr`, `mem_mem_read`, `alu_result_reg` and `mem_rdata` to the writeback stage. Stalls the pipeline through valid/allowin handshakes on both sides.

Parameters:
- `DATA_W`, 32, datapath and SRAM data width. Only 32 is supported.
- `RADDR_W`, 5, register-file write-address width.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `exe_valid`  in  1  execute stage holds a valid instruction.
- `mem_allowin`  out  1  this stage can accept an instruction this cycle.
- `exe_reg_en`  in  1  instruction writes the register file.
- `exe_reg_waddr`  in  `RADDR_W`  destination register.
- `exe_mem_read`  in  1  load instruction.
- `exe_mem_write`  in  1  store instruction.
- `exe_mem_size`  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- `exe_mem_unsigned`  in  1  load zero-extends when set, sign-extends when clear.
- `exe_alu_result`  in  32  ALU result; this is the effective address for memory operations.
- `exe_store_data`  in  32  store source register value.
- `data_req`  out  1  SRAM request.
- `data_wr`  out  1  1 = write, 0 = read.
- `data_wstrb`  out  4  byte write strobes; 0000 on reads.
- `data_addr`  out  32  word-aligned SRAM address.
- `data_wdata`  out  32  store data, lane-replicated.
- `data_addr_ok`  in  1  SRAM has accepted the request.
- `data_data_ok`  in  1  read data is valid, or the write has completed.
- `data_rdata`  in  32  SRAM read data.
- `mem_valid`  out  1  writeback-bound instruction is valid.
- `wb_allowin`  in  1  writeback stage accepts this cycle.
- `mem_reg_en`  out  1  register write enable, gated by `mem_valid`.
- `mem_reg_waddr`  out  `RADDR_W`  destination register.
- `mem_mem_read`  out  1  selects `mem_rdata` over `alu_result_reg` in writeback.
- `alu_result_reg`  out  32  registered ALU result.
- `mem_rdata`  out  32  aligned and extended load data.

Behaviour:

Reset
- Reset is synchronous and active-high: `reset` sampled high at a rising edge forces the state to IDLE.
- Every output register resets to 0.
- Reset results: `mem_valid`=0, `mem_reg_en`=0, `data_req`=0, `mem_allowin`=1 on the first cycle after reset.
- Reset wins over every other event in the same cycle.
- The data SRAM shares this reset, so no response outstanding at reset is delivered afterwards.

State machine (IDLE, REQ, WAIT, DONE)
- Acceptance happens when `exe_valid` && `mem_allowin`. All `exe_*` inputs are latched at that edge.
- From acceptance:
  - If `exe_mem_read` or `exe_mem_write` → REQ.
  - Otherwise → DONE.
- REQ: `data_req`=1. Address, write, strobe and data outputs are held stable. When `data_addr_ok`=1 → WAIT.
- WAIT: `data_req`=0. When `data_data_ok`=1, the aligned load data is captured into `mem_rdata` → DONE.
  - Stores also wait for `data_data_ok`.
  - `data_data_ok` arriving in the same cycle as `data_addr_ok` is not accepted; the minimum memory latency is 2 cycles after REQ entry.
- DONE: `mem_valid`=1. When `wb_allowin`=1 the instruction leaves.
  - If a new acceptance happens in the same cycle → REQ or DONE per the new instruction.
  - Otherwise → IDLE.
- `mem_allowin` = (state==IDLE) || (state==DONE && `wb_allowin`).
- Outputs to writeback are stable while DONE and `wb_allowin`=0.

Latency
- Non-memory instruction: 1 cycle.
- Memory instruction: 2 + SRAM wait cycles.

Address and strobes
- `data_addr` = {addr[31:2], 2'b00}.
- Byte store: `data_wstrb` = 0001 << addr[1:0]; `data_wdata` = the low byte replicated ×4.
- Half store: `data_wstrb` = 0011 << {addr[1],1'b0}; `data_wdata` = the low half replicated ×2.
- Word store: `data_wstrb` = 1111.
- Without the optional feature, address bits below the access size are ignored (half uses addr[1] only; word ignores addr[1:0]).

Load alignment
- The byte/half lane is selected by address bits, then zero- or sign-extended per `exe_mem_unsigned` to 32 bits.

Optional Feature:
`MEM_ALIGN_CHECK_EN`
- Defined:
  - Adds output `mem_exc` (1 bit, reset 0).
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no SRAM request. The stage goes straight to DONE with `mem_exc`=1 and `mem_reg_en`=0.
  - `mem_exc` is valid only while `mem_valid`=1.
- Undefined: the port is absent and low-order address bits are ignored as described under Address and strobes.

Test Plan:
- Reset mid-WAIT (`data_data_ok` never returns) → next cycle state IDLE, `mem_valid`=0, `data_req`=0, `mem_allowin`=1.
- Non-memory op, `exe_alu_result`=0x1234, `wb_allowin`=1, back-to-back `exe_valid` → one result per cycle; `mem_reg_en`=1, `alu_result_reg`=0x1234, `data_req` never asserted.
- LB at addr 0x103, `exe_mem_unsigned`=0, `data_rdata`=0x80FF_FFFF, `data_addr_ok` delayed 2 cycles, `data_data_ok` 1 cycle later → `data_addr`=0x100, `data_req` high for exactly 3 cycles, `mem_rdata`=0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- SH at addr 0x202, store data 0xABCD_1234 → `data_wstrb`=1100, `data_wdata`=0x1234_1234, `data_wr`=1; `mem_reg_en`=0 in DONE.
- Load in DONE with `wb_allowin`=0 for 3 cycles while `exe_valid`=1 → `mem_allowin`=0 and outputs frozen. When `wb_allowin` goes to 1, the next instruction is accepted in the same cycle.
- With `MEM_ALIGN_CHECK_EN`: LW at 0x1002 → no `data_req`; `mem_valid`=1 with `mem_exc`=1 and `mem_reg_en`=0, one cycle after acceptance.
